fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_read  output  1  instruction memory read request; held high until imem_resp.
REQ-005 imem_address  output  16  fetch address; constant while a request is outstanding.
REQ-006 imem_resp  input  1  one-cycle read-complete strobe.
REQ-007 imem_rdata  input  16  instruction word, valid with imem_resp.
REQ-008 br_taken  input  1  one-cycle redirect pulse from a later stage.
REQ-009 br_target  input  16  redirect address, valid with br_taken.
REQ-010 stall  input  1  downstream cannot accept the current output this cycle.
REQ-011 if_valid  output  1  if_ir/if_pc hold a live instruction.
REQ-012 if_ir  output  16  fetched instruction word.
REQ-013 if_pc  output  16  fetch address + 2.
REQ-014 opcode  output  4  if_ir[15:12]; bit11, bit5, bit4 outputs (1 bit each) are if_ir[11], if_ir[5], if_ir[4] for the control ROM.

Function
REQ-015 The block SHALL hold an output register (if_*) and one skid entry (skid_ir, skid_pc, skid_valid), forming a 2-deep instruction buffer.
REQ-016 The FSM SHALL have states FETCH, FULL, SQUASH.
REQ-017 FETCH: imem_read=1, imem_address=pc; on imem_resp, pc<=pc+2 and response goes to output register if (!if_valid || !stall), else to skid, moving to FULL.
REQ-018 FULL: imem_read=0; on !stall, skid moves to output register, skid_valid<=0, next state FETCH.
REQ-019 Output register SHALL be consumed when if_valid && !stall; if_valid clears unless a new entry loads in the same cycle.
REQ-020 Latency: imem_resp in cycle N with free output -> if_valid=1, if_ir=imem_rdata, if_pc=address+2 in cycle N+1; next request issued in cycle N+1 at address+2 with imem_read continuously high.
REQ-021 br_taken SHALL have priority over stall and imem_resp: next cycle if_valid=0, skid_valid=0, pc=br_target.
REQ-022 br_taken with a request outstanding and no imem_resp the same cycle -> SQUASH: imem_read and old imem_address held; arriving response discarded; then FETCH at br_target.
REQ-023 br_taken in the same cycle as imem_resp -> response discarded; next state FETCH with imem_address=br_target.
REQ-024 br_taken during SQUASH SHALL overwrite the pending target; the latest target wins.
REQ-025 pc arithmetic SHALL be 16-bit modulo; 16'hFFFE+2 wraps to 16'h0000.
REQ-026 Instructions SHALL leave in fetch order with none duplicated or dropped except on redirect.

Reset
REQ-027 On reset assertion, immediately: state=FETCH, pc=RESET_PC, if_valid=0, skid_valid=0, if_ir=0, if_pc=0; imem_read goes low while reset is high.
REQ-028 Reset mid-request SHALL abandon the request; the first cycle after release SHALL show imem_read=1 with imem_address=RESET_PC.

Configuration
REQ-029 With IF_STALL_CNT_EN defined, output stall_count (16) SHALL count cycles with if_valid && stall, saturate at 16'hFFFF, clear on reset.
REQ-030 Without IF_STALL_CNT_EN, port stall_count and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset release, memory resp after 2 cycles with rdata 16'h1234, stall=0 -> if_valid=1, if_ir=16'h1234, if_pc=16'h0002, opcode=4'h1; next address 16'h0002.
REQ-032 stall held high, three back-to-back responses 16'hA001/A002/A003 -> first two kept (output+skid), imem_read=0 in FULL, third not requested; stall release -> A001, A002, A003 delivered in order.
REQ-033 br_taken (target 16'h0040) while request to 16'h0010 outstanding -> imem_address stays 16'h0010 until resp, data discarded, next request 16'h0040, if_valid=0 throughout.
REQ-034 br_taken and imem_resp same cycle, target 16'h0080 -> response dropped, next imem_address=16'h0080, if_valid=0.
REQ-035 pc=16'hFFFE fetch -> if_pc=16'h0000, next imem_address=16'h0000; reset asserted mid-request -> imem_read drops same cycle, restart at RESET_PC.
REQ-036 IF_STALL_CNT_EN: if_valid=1, stall high 5 cycles -> stall_count=5; without macro, build with no stall_count port succeeds.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a 2-deep output buffer (output reg + skid).
// Issues imem reads, handles redirects (squashing in-flight reads) and stalls.
// Ports:
//   clk, reset (async, active-high)
//   imem_read/imem_address -> instruction memory request
//   imem_resp/imem_rdata   <- one-cycle read completion
//   br_taken/br_target     <- redirect pulse from a later stage
//   stall                  <- downstream cannot accept this cycle
//   if_valid/if_ir/if_pc   -> fetched instruction, pc = fetch address + 2
//   opcode, bit11, bit5, bit4 -> decode fields of if_ir
//   stall_count            -> only with IF_STALL_CNT_EN: saturating count of
//                             cycles with if_valid && stall
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        stall,
  output logic        if_valid,
  output logic [15:0] if_ir,
  output logic [15:0] if_pc,
  output logic [3:0]  opcode,
  output logic        bit11,
  output logic        bit5,
  output logic        bit4
`ifdef IF_STALL_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    SQUASH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] tgt_q, tgt_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] if_ir_q, if_ir_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_ir_q, skid_ir_d;
  logic [15:0] skid_pc_q, skid_pc_d;

  logic [15:0] pc_inc;
  logic        consume;

  assign pc_inc  = pc_q + 16'd2;
  assign consume = if_valid_q && !stall;

  // Reset forces the request low combinationally so an in-flight
  // read is abandoned in the same cycle reset rises.
  assign imem_read    = !reset && (state_q != FULL);
  assign imem_address = pc_q;

  assign if_valid = if_valid_q;
  assign if_ir    = if_ir_q;
  assign if_pc    = if_pc_q;
  assign opcode   = if_ir_q[15:12];
  assign bit11    = if_ir_q[11];
  assign bit5     = if_ir_q[5];
  assign bit4     = if_ir_q[4];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    if_valid_d   = if_valid_q;
    if_ir_d      = if_ir_q;
    if_pc_d      = if_pc_q;
    skid_valid_d = skid_valid_q;
    skid_ir_d    = skid_ir_q;
    skid_pc_d    = skid_pc_q;
    if (br_taken) begin
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      // A read still in flight must finish before the new
      // address can be presented; park the target meanwhile.
      if (state_q != FULL && !imem_resp) begin
        state_d = SQUASH;
        tgt_d   = br_target;
      end else begin
        state_d = FETCH;
        pc_d    = br_target;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (consume) if_valid_d = 1'b0;
          if (imem_resp) begin
            pc_d = pc_inc;
            if (!if_valid_q || !stall) begin
              if_valid_d = 1'b1;
              if_ir_d    = imem_rdata;
              if_pc_d    = pc_inc;
            end else begin
              skid_valid_d = 1'b1;
              skid_ir_d    = imem_rdata;
              skid_pc_d    = pc_inc;
              state_d      = FULL;
            end
          end
        end
        FULL: begin
          if (!stall) begin
            if_valid_d   = skid_valid_q;
            if_ir_d      = skid_ir_q;
            if_pc_d      = skid_pc_q;
            skid_valid_d = 1'b0;
            state_d      = FETCH;
          end
        end
        SQUASH: begin
          if (consume) if_valid_d = 1'b0;
          if (imem_resp) begin
            pc_d    = tgt_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      tgt_q        <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_ir_q      <= 16'h0000;
      if_pc_q      <= 16'h0000;
      skid_valid_q <= 1'b0;
      skid_ir_q    <= 16'h0000;
      skid_pc_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      if_valid_q   <= if_valid_d;
      if_ir_q      <= if_ir_d;
      if_pc_q      <= if_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_ir_q    <= skid_ir_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

`ifdef IF_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (if_valid_q && stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= 16'h0000;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by randomized traffic
// checked through an expected-instruction queue and a monitor.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        br_taken;
  logic [15:0] br_target;
  logic        stall;
  logic        if_valid;
  logic [15:0] if_ir;
  logic [15:0] if_pc;
  logic [3:0]  opcode;
  logic        bit11;
  logic        bit5;
  logic        bit4;
`ifdef IF_STALL_CNT_EN
  logic [15:0] stall_count;
  logic [15:0] sc_model;
`endif

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .stall        (stall),
    .if_valid     (if_valid),
    .if_ir        (if_ir),
    .if_pc        (if_pc),
    .opcode       (opcode),
    .bit11        (bit11),
    .bit5         (bit5),
    .bit4         (bit4)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] sbq[$];
  bit          sb_on = 0;

  bit          busy = 0;
  bit          stale = 0;
  logic [15:0] lat_addr = 16'h0000;
  logic [15:0] exp_addr = 16'h0000;
  int          wait_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hA5C3 ^ (a << 3);
  endfunction

  // Monitor: pops an expected instruction whenever one is handed off.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [15:0] e_ir;
    #2;
`ifdef IF_STALL_CNT_EN
    if (reset) sc_model = 16'h0000;
    chk("stall_count", stall_count, sc_model);
    if (!reset && if_valid && stall && sc_model != 16'hFFFF)
      sc_model = sc_model + 16'd1;
`endif
    if (sb_on && !reset) begin
      if (if_valid && !stall) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got ir %h pc %h expected nothing",
                   if_ir, if_pc);
        end else begin
          e = sbq.pop_front();
          e_ir = e[31:16];
          chk("sb_ir", if_ir, e_ir);
          chk("sb_pc", if_pc, e[15:0]);
          chk("sb_dec", {opcode, bit11, bit5, bit4},
              {e_ir[15:12], e_ir[11], e_ir[5], e_ir[4]});
        end
      end
      if (br_taken) sbq.delete();
    end
  end

  // One randomized memory/redirect/stall cycle; quiet drains without
  // starting new reads or redirects.
  task automatic rand_cycle(input bit quiet);
    logic [15:0] tgt;
    bit          do_br;
    @(negedge clk);
    imem_resp  = 1'b0;
    br_taken   = 1'b0;
    imem_rdata = 16'($urandom);
    tgt        = 16'h0000;
    if (busy) begin
      chk("rd_held", imem_read, 1'b1);
      chk("addr_held", imem_address, lat_addr);
    end else if (imem_read && !quiet) begin
      chk("req_addr", imem_address, exp_addr);
      busy     = 1;
      stale    = 0;
      lat_addr = imem_address;
      wait_cnt = $urandom_range(0, 3);
    end
    if (busy) begin
      if (wait_cnt == 0) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(lat_addr);
      end else begin
        wait_cnt--;
      end
    end
    do_br = !quiet && ($urandom_range(0, 11) == 0);
    if (do_br) begin
      if ($urandom_range(0, 5) == 0) tgt = 16'hFFFA;
      else tgt = 16'($urandom_range(0, 32767)) << 1;
      br_taken  = 1'b1;
      br_target = tgt;
      if (busy) stale = 1;
    end
    if (imem_resp) begin
      if (!stale) begin
        sbq.push_back({mem_word(lat_addr), lat_addr + 16'd2});
        exp_addr = lat_addr + 16'd2;
      end
      busy = 0;
    end
    if (do_br) exp_addr = tgt;
    stall = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    reset      = 1'b1;
    imem_resp  = 1'b0;
    imem_rdata = 16'h0000;
    br_taken   = 1'b0;
    br_target  = 16'h0000;
    stall      = 1'b0;

    // Reset state and first fetch.
    @(negedge clk);
    chk("rst_read", imem_read, 1'b0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_ir", if_ir, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    reset = 1'b0;
    #1;
    chk("rel_read", imem_read, 1'b1);
    chk("rel_addr", imem_address, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    imem_resp = 1'b1; imem_rdata = 16'h1234;
    @(negedge clk);
    chk("first_valid", if_valid, 1'b1);
    chk("first_ir", if_ir, 16'h1234);
    chk("first_pc", if_pc, 16'h0002);
    chk("first_op", opcode, 4'h1);
    chk("first_next", imem_address, 16'h0002);
    chk("first_read", imem_read, 1'b1);
    imem_resp = 1'b0;
    @(negedge clk);
    chk("consumed", if_valid, 1'b0);

    // Back-to-back responses under stall fill output and skid.
    stall = 1'b1; imem_resp = 1'b1; imem_rdata = 16'hA001;
    @(negedge clk);
    chk("a001_ir", if_ir, 16'hA001);
    imem_rdata = 16'hA002;
    @(negedge clk);
    chk("full_read", imem_read, 1'b0);
    chk("full_ir", if_ir, 16'hA001);
    chk("full_pc", if_pc, 16'h0004);
    chk("full_valid", if_valid, 1'b1);
    imem_resp = 1'b0;
    @(negedge clk);
    chk("full_hold", imem_read, 1'b0);
    stall = 1'b0;
    @(negedge clk);
    chk("a002_ir", if_ir, 16'hA002);
    chk("a002_pc", if_pc, 16'h0006);
    chk("a003_req", imem_read, 1'b1);
    chk("a003_addr", imem_address, 16'h0006);
    imem_resp = 1'b1; imem_rdata = 16'hA003;
    @(negedge clk);
    chk("a003_ir", if_ir, 16'hA003);
    chk("a003_pc", if_pc, 16'h0008);

    // Redirect with a read outstanding, then redirect during squash.
    imem_resp = 1'b0; br_taken = 1'b1; br_target = 16'h0010;
    @(negedge clk);
    chk("sq_addr", imem_address, 16'h0008);
    chk("sq_read", imem_read, 1'b1);
    chk("sq_valid", if_valid, 1'b0);
    br_taken = 1'b0; imem_resp = 1'b1; imem_rdata = 16'hDEAD;
    @(negedge clk);
    chk("sq_new", imem_address, 16'h0010);
    chk("sq_drop", if_valid, 1'b0);
    imem_resp = 1'b0; br_taken = 1'b1; br_target = 16'h0050;
    @(negedge clk);
    chk("sq2_addr", imem_address, 16'h0010);
    chk("sq2_valid", if_valid, 1'b0);
    br_target = 16'h0040;
    @(negedge clk);
    chk("sq3_addr", imem_address, 16'h0010);
    br_taken = 1'b0; imem_resp = 1'b1; imem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("sq_latest", imem_address, 16'h0040);
    chk("sq3_valid", if_valid, 1'b0);

    // Redirect coinciding with a response.
    br_taken = 1'b1; br_target = 16'h0080; imem_rdata = 16'h1111;
    @(negedge clk);
    chk("brr_addr", imem_address, 16'h0080);
    chk("brr_valid", if_valid, 1'b0);
    chk("brr_read", imem_read, 1'b1);

    // Wrap at the top of the address space.
    br_target = 16'hFFFE;
    @(negedge clk);
    chk("wrap_req", imem_address, 16'hFFFE);
    br_taken = 1'b0; imem_rdata = 16'h5678;
    @(negedge clk);
    chk("wrap_ir", if_ir, 16'h5678);
    chk("wrap_pc", if_pc, 16'h0000);
    chk("wrap_next", imem_address, 16'h0000);
    chk("wrap_op", opcode, 4'h5);
    imem_rdata = 16'h9ABC;
    @(negedge clk);
    chk("post_wrap", imem_address, 16'h0002);
    chk("post_ir", if_ir, 16'h9ABC);

    // Reset while a read is outstanding.
    imem_resp = 1'b0;
    #4 reset = 1'b1;
    #1;
    chk("mrst_read", imem_read, 1'b0);
    chk("mrst_valid", if_valid, 1'b0);
    chk("mrst_ir", if_ir, 16'h0000);
    chk("mrst_pc", if_pc, 16'h0000);
    @(negedge clk);
    chk("mrst_hold", imem_read, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_rel_read", imem_read, 1'b1);
    chk("mrst_rel_addr", imem_address, 16'h0000);

    // Randomized traffic against the queue-based model.
    exp_addr = 16'h0000;
    busy = 0;
    sbq.delete();
    sb_on = 1;
    for (int i = 0; i < 3000; i++) rand_cycle(0);
    for (int i = 0; i < 30; i++) rand_cycle(1);
    @(negedge clk);
    #3;
    chk("drain_q", sbq.size(), 0);
    chk("drain_valid", if_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
